// File: rtl/adc_capture_pkg.sv
// Shared types and sizing helpers for the SAR ADC capture block.
package adc_capture_pkg;

  typedef enum logic [2:0] {IDLE, CNV, WAIT, SHIFT, DONE, VALID} state_e;

  function automatic int frame_len(input int adc_width, input int cnv_high,
                                   input int conv_wait, input int sck_div,
                                   input int valid_cycles);
    return cnv_high + conv_wait + 2 * sck_div * adc_width + 1 + valid_cycles;
  endfunction

  function automatic int bit_cnt_w(input int adc_width);
    return $clog2(adc_width + 1);
  endfunction

endpackage

// File: rtl/adc_serial_shifter.sv
// SCK generator and MSB-first serial receiver for one conversion result.
module adc_serial_shifter
  import adc_capture_pkg::*;
#(
  parameter int ADC_WIDTH = 18,
  parameter int SCK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic                 sdo_i,
  output logic                 sck_o,
  output logic                 done_o,
  output logic [ADC_WIDTH-1:0] data_o
);

  localparam int BW = bit_cnt_w(ADC_WIDTH);
  localparam int DW = $clog2(SCK_DIV + 1);

  logic                 active_q, active_d;
  logic                 sck_q, sck_d;
  logic [DW-1:0]        div_q, div_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [ADC_WIDTH-1:0] sh_q, sh_d;
  logic                 phase_end, last_bit;

  assign phase_end = active_q && (div_q == DW'(SCK_DIV - 1));
  assign last_bit  = (bit_q == BW'(ADC_WIDTH - 1));

  // Combinational so the controller can leave SHIFT on the final falling edge.
  assign done_o = phase_end && sck_q && last_bit;
  assign sck_o  = sck_q;
  assign data_o = sh_q;

  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    if (start_i) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      div_d    = '0;
      bit_d    = '0;
    end else if (active_q) begin
      if (phase_end) begin
        div_d = '0;
        sck_d = ~sck_q;
        // Sample on the high->low transition of sck.
        if (sck_q) begin
          sh_d  = {sh_q[ADC_WIDTH-2:0], sdo_i};
          bit_d = bit_q + 1'b1;
          if (last_bit) active_d = 1'b0;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
    end
  end

endmodule

// File: rtl/adc_serial_capture.sv
// Periodic conversion controller for the 18-bit SAR ADC: CNV pulse, wait, serial
// readout, then a multi-cycle adc_valid strobe with the latched result.
module adc_serial_capture
  import adc_capture_pkg::*;
#(
  parameter int ADC_WIDTH        = 18,
  parameter int SAMPLE_PERIOD    = 125,
  parameter int CNV_HIGH_CYCLES  = 4,
  parameter int CONV_WAIT_CYCLES = 40,
  parameter int SCK_DIV          = 2,
  parameter int VALID_CYCLES     = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 overrun_clr,
  input  logic                 sdo,
  output logic                 cnv,
  output logic                 sck,
  output logic [ADC_WIDTH-1:0] adc_data,
  output logic                 adc_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int PW   = $clog2(SAMPLE_PERIOD + 1);
  localparam int MAXC = (CNV_HIGH_CYCLES > CONV_WAIT_CYCLES) ?
                        ((CNV_HIGH_CYCLES > VALID_CYCLES) ? CNV_HIGH_CYCLES : VALID_CYCLES) :
                        ((CONV_WAIT_CYCLES > VALID_CYCLES) ? CONV_WAIT_CYCLES : VALID_CYCLES);
  localparam int CW   = $clog2(MAXC + 1);

  state_e               state_q;
  logic [PW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        cyc_q;
  logic                 cnv_q, busy_q, valid_q, ovr_q;
  logic [ADC_WIDTH-1:0] data_q;
  logic                 tick, sh_start, sh_done;
  logic [ADC_WIDTH-1:0] sh_data;

  assign tick     = enable && (cnt_q == '0);
  assign sh_start = (state_q == WAIT) && (cyc_q == CW'(CONV_WAIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!enable || cnt_q == PW'(SAMPLE_PERIOD - 1)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  adc_serial_shifter #(
    .ADC_WIDTH (ADC_WIDTH),
    .SCK_DIV   (SCK_DIV)
  ) u_shifter (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (sh_start),
    .sdo_i   (sdo),
    .sck_o   (sck),
    .done_o  (sh_done),
    .data_o  (sh_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      cnv_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      // A tick outside IDLE is dropped; the sticky flag beats a same-cycle clear.
      if (tick && state_q != IDLE) ovr_q <= 1'b1;
      else if (overrun_clr)        ovr_q <= 1'b0;

      case (state_q)
        IDLE: if (tick) begin
          state_q <= CNV;
          cnv_q   <= 1'b1;
          busy_q  <= 1'b1;
          cyc_q   <= '0;
        end
        CNV: if (cyc_q == CW'(CNV_HIGH_CYCLES - 1)) begin
          state_q <= WAIT;
          cnv_q   <= 1'b0;
          cyc_q   <= '0;
        end else cyc_q <= cyc_q + 1'b1;
        WAIT: if (sh_start) begin
          state_q <= SHIFT;
          cyc_q   <= '0;
        end else cyc_q <= cyc_q + 1'b1;
        SHIFT: if (sh_done) state_q <= DONE;
        DONE: begin
          state_q <= VALID;
          data_q  <= sh_data;
          valid_q <= 1'b1;
          cyc_q   <= '0;
        end
        VALID: if (cyc_q == CW'(VALID_CYCLES - 1)) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end else cyc_q <= cyc_q + 1'b1;
        default: begin
          state_q <= IDLE;
          cnv_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cnv       = cnv_q;
  assign busy      = busy_q;
  assign adc_valid = valid_q;
  assign adc_data  = data_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed bench: default instance for frame timing/data, a short-period instance for
// overrun, and two SCK_DIV variants watched by an sck phase monitor.
module tb_adc_serial_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_cnv = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- main instance (defaults) ----------------
  logic        rstn, en, oclr, sdo, cnv, sck, valid, busy, ovr;
  logic [17:0] data;
  logic [17:0] word = 18'h0;
  int          nfall = 18;

  // SDO model: MSB presented at cnv rise, next bit after each sck falling edge.
  always @(posedge cnv or negedge sck) begin
    if (cnv) nfall = 0;
    else     nfall++;
  end
  assign sdo = (nfall >= 0 && nfall < 18) ? word[17 - nfall] : 1'b0;

  adc_serial_capture u_dut (
    .clk(clk), .resetn(rstn), .enable(en), .overrun_clr(oclr), .sdo(sdo),
    .cnv(cnv), .sck(sck), .adc_data(data), .adc_valid(valid), .busy(busy), .overrun(ovr)
  );

  // ---------------- overrun instance (SAMPLE_PERIOD=100) ----------------
  logic        rstn_o, en_o, oclr_o, cnv_o, sck_o, valid_o, busy_o, ovr_o;
  logic [17:0] data_o;

  adc_serial_capture #(.SAMPLE_PERIOD(100)) u_ovr (
    .clk(clk), .resetn(rstn_o), .enable(en_o), .overrun_clr(oclr_o), .sdo(1'b0),
    .cnv(cnv_o), .sck(sck_o), .adc_data(data_o), .adc_valid(valid_o), .busy(busy_o),
    .overrun(ovr_o)
  );

  // ---------------- SCK_DIV=1 / SCK_DIV=3 instances with phase monitor ----------------
  logic       rst_s = 1'b0;
  logic [1:0] cnv_v, sck_v, valid_v, busy_v, ovr_v;

  for (genvar g = 0; g < 2; g++) begin : g_sck
    localparam int DIV = (g == 0) ? 1 : 3;
    logic [17:0] data_s;
    int   run = 0, pulses = 0, frames = 0;
    logic ps = 1'b0, pc = 1'b0;

    adc_serial_capture #(.SCK_DIV(DIV), .SAMPLE_PERIOD((g == 0) ? 125 : 160)) u_s (
      .clk(clk), .resetn(rst_s), .enable(1'b1), .overrun_clr(1'b0), .sdo(1'b0),
      .cnv(cnv_v[g]), .sck(sck_v[g]), .adc_data(data_s), .adc_valid(valid_v[g]),
      .busy(busy_v[g]), .overrun(ovr_v[g])
    );

    always @(negedge clk) begin
      if (rst_s) begin
        if (cnv_v[g] && !pc) begin
          if (frames > 0) chk("sck_pulses", pulses, 18);
          frames++;
          pulses = 0;
        end
        if (sck_v[g] != ps) begin
          if (ps) chk("sck_high", run, DIV);
          else begin
            if (pulses > 0) chk("sck_low", run, DIV);
            chk("sck_in_frame", {busy_v[g], cnv_v[g]}, 2'b10);
            pulses++;
          end
          run = 1;
        end else run++;
        ps = sck_v[g];
        pc = cnv_v[g];
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_cnv(output int gap);
    logic p;
    p   = cnv;
    gap = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cnv && !p) begin
        gap = cyc - last_cnv;
        last_cnv = cyc;
        return;
      end
      p = cnv;
    end
    chk("cnv_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (valid) return;
    end
    chk("valid_timeout", 0, 1);
  endtask

  task automatic valid_width(output int w);
    w = 0;
    for (int i = 0; i < 20; i++) begin
      if (!valid) return;
      w++;
      @(negedge clk);
    end
  endtask

  logic [17:0] t2_words [3] = '{18'h00000, 18'h3FFFF, 18'h20000};

  initial begin
    int n, w, gap, hi, rises;
    logic pb;
    rstn = 1'b0; en = 1'b1; oclr = 1'b0;
    rstn_o = 1'b0; en_o = 1'b1; oclr_o = 1'b0;
    word = 18'h2A5C3;
    repeat (3) @(negedge clk);
    rst_s = 1'b1;

    // 1. reset values, first frame after reset release
    chk("rst_cnv", cnv, 0);
    chk("rst_sck", sck, 0);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    rstn = 1'b1;
    chk("t1_cnv_before", cnv, 0);
    @(negedge clk);
    chk("t1_cnv_rise", cnv, 1);
    last_cnv = cyc;
    wait_valid(n);
    chk("t1_latency", n + 1, 118);
    chk("t1_data", data, 18'h2A5C3);
    valid_width(w);
    chk("t1_vwidth", w, 2);

    // 2. free running, period and MSB-first order
    for (int i = 0; i < 3; i++) begin
      word = t2_words[i];
      wait_cnv(gap);
      chk("t2_period", gap, 125);
      chk("t2_valid_gap", valid, 0);
      wait_valid(n);
      chk("t2_latency", n, 117);
      chk("t2_data", data, t2_words[i]);
      valid_width(w);
      chk("t2_vwidth", w, 2);
    end

    // 3. drop enable mid-SHIFT, then re-raise
    word = 18'h15A5A;
    wait_cnv(gap);
    repeat (63) @(negedge clk);
    chk("t3_busy", busy, 1);
    en = 1'b0;
    wait_valid(n);
    chk("t3_data", data, 18'h15A5A);
    hi = 0;
    repeat (300) begin
      @(negedge clk);
      if (cnv) hi++;
    end
    chk("t3_no_cnv", hi, 0);
    chk("t3_idle", busy, 0);
    word = 18'h0F0F1;
    en = 1'b1;
    chk("t3_cnv_pre", cnv, 0);
    @(negedge clk);
    chk("t3_cnv_rise", cnv, 1);
    wait_valid(n);
    chk("t3_data2", data, 18'h0F0F1);

    // 5. reset mid-SHIFT
    repeat (4) @(negedge clk);
    word = 18'h3C3C3;
    wait_cnv(gap);
    repeat (63) @(negedge clk);
    chk("t5_sck_high", sck, 1);
    rstn = 1'b0;
    #1;
    chk("t5_cnv", cnv, 0);
    chk("t5_sck", sck, 0);
    chk("t5_valid", valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_data", data, 0);
    repeat (2) @(negedge clk);
    word = 18'h1B2E7;
    rstn = 1'b1;
    wait_valid(n);
    chk("t5_latency", n, 118);
    chk("t5_data2", data, 18'h1B2E7);

    // 4. overrun with SAMPLE_PERIOD=100
    @(negedge clk);
    rstn_o = 1'b1;
    rises = 0;
    pb = busy_o;
    for (int i = 1; i <= 320; i++) begin
      @(negedge clk);
      if (busy_o && !pb) rises++;
      pb = busy_o;
      if (i == 100) chk("t4_ovr_pre", ovr_o, 0);
      if (i == 101) chk("t4_ovr_set", ovr_o, 1);
      if (i == 150) oclr_o = 1'b1;
      if (i == 151) begin oclr_o = 1'b0; chk("t4_ovr_clr", ovr_o, 0); end
      if (i == 201) chk("t4_cnv_restart", cnv_o, 1);
      if (i == 300) oclr_o = 1'b1;
      if (i == 301) begin oclr_o = 1'b0; chk("t4_set_wins", ovr_o, 1); end
      if (i == 305) oclr_o = 1'b1;
      if (i == 306) begin oclr_o = 1'b0; chk("t4_ovr_clr2", ovr_o, 0); end
    end
    chk("t4_busy_rises", rises, 2);

    // 6. SCK_DIV variants ran alongside everything above
    chk("t6_frames_div1", g_sck[0].frames >= 3, 1);
    chk("t6_frames_div3", g_sck[1].frames >= 3, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
